instruction_mem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory. It takes a byte stream over a valid/ready

---
 rtl/instruction_mem_loader.sv | 157 +++++++++++++++
 tb/tb_instruction_mem_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_mem_loader.sv
// Byte-stream to 16-bit instruction word loader for the instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and chk_err.
module instruction_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    output logic              chk_err
);

    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] cur_adr;
    logic [ADDR_W:0]   count;
    logic [7:0]        hi_byte;
    logic [ADDR_W:0]   cnt_sat;
    logic [ADDR_W:0]   ww_inc;
    logic              accept;

    assign cnt_sat  = (word_cnt > MAX_CNT) ? MAX_CNT : word_cnt;
    assign ww_inc   = words_written + 1'b1;
    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE);
    assign cpu_hold = busy;

    // Next-state and handshake decode
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = (cnt_sat == '0) ? DONE : GET_HI;
                end
            end
            GET_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_n = GET_LO;
            end
            GET_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_n = WRITE;
            end
            WRITE: begin
                if (ww_inc == count) begin
`ifdef LOADER_CHECKSUM_EN
                    state_n = CHECK;
`else
                    state_n = DONE;
`endif
                end else begin
                    state_n = GET_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                if (in_valid) state_n = DONE;
            end
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Datapath: address/count tracking, word assembly and output strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_adr       <= '0;
            count         <= '0;
            hi_byte       <= '0;
            mem_we        <= 1'b0;
            mem_adr       <= '0;
            mem_wdata     <= '0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            mem_we <= (state == WRITE);
            done   <= (state == DONE);
            if (state == IDLE && start) begin
                cur_adr       <= base_adr;
                count         <= cnt_sat;
                words_written <= '0;
            end
            if (state == GET_HI && accept) begin
                hi_byte <= in_data;
            end
            if (state == GET_LO && accept) begin
                mem_wdata <= {hi_byte, in_data};
                mem_adr   <= cur_adr;
            end
            if (state == WRITE) begin
                cur_adr       <= cur_adr + 1'b1;
                words_written <= ww_inc;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;

    // Running XOR of data bytes, compared against the trailing checksum byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_acc <= '0;
            chk_err <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                xor_acc <= '0;
                chk_err <= 1'b0;
            end
            if ((state == GET_HI || state == GET_LO) && accept) begin
                xor_acc <= xor_acc ^ in_data;
            end
            if (state == CHECK && accept) begin
                chk_err <= (in_data != xor_acc);
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Scoreboard bench for instruction_mem_loader with a queue-based source and
// a word-level reference model of the expected memory writes and completions.
module tb_instruction_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_adr;
    logic [10:0] word_cnt;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_adr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [10:0] words_written;
    logic        chk_err;

    instruction_mem_loader #(.ADDR_W(10), .WORD_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_adr(base_adr),
        .word_cnt(word_cnt), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .words_written(words_written), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  adr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int   words;
        logic chk;
        bit   zero;
        int   scyc;
    } dn_t;

    wr_t        wq[$];
    dn_t        dq[$];
    logic [7:0] src_q[$];
    logic [7:0] fix[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_we_cyc = 0;
    int         vmode = 0;
    bit         hs = 1'b0;
    bit         tog = 1'b0;
    logic [7:0] junk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source: presents the head of src_q, pops it after a completed handshake
    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (hs && src_q.size() > 0) junk = src_q.pop_front();
            tog = ~tog;
            if (src_q.size() > 0 && (vmode == 0 || (vmode == 1 && tog) ||
                (vmode == 2 && $urandom_range(0, 1) == 1))) begin
                in_valid = 1'b1;
                in_data  = src_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom_range(0, 255));
            end
            #1 hs = in_valid && in_ready;
        end
    end

    // Monitor: pops expectations whenever the DUT writes or completes
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write adr=%0d data=%h", mem_adr, mem_wdata);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    if (mem_adr !== w.adr || mem_wdata !== w.data) begin
                        bad++;
                        $display("FAIL write got %0d:%h want %0d:%h",
                                 mem_adr, mem_wdata, w.adr, w.data);
                    end
                end
                last_we_cyc = cyc;
            end
            if (done) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done ww=%0d", words_written);
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    if (int'(words_written) != d.words || chk_err !== d.chk) begin
                        bad++;
                        $display("FAIL done_state ww=%0d chk=%b want ww=%0d chk=%b",
                                 words_written, chk_err, d.words, d.chk);
                    end
                    total++;
                    if (d.zero) begin
                        if (cyc - d.scyc != 2) begin
                            bad++;
                            $display("FAIL zero_done_lat got=%0d want=2", cyc - d.scyc);
                        end
                    end else begin
`ifndef LOADER_CHECKSUM_EN
                        if (cyc - last_we_cyc != 1) begin
                            bad++;
                            $display("FAIL done_after_we got=%0d want=1", cyc - last_we_cyc);
                        end
`else
                        if (cyc - last_we_cyc < 2) begin
                            bad++;
                            $display("FAIL done_after_we got=%0d want>=2", cyc - last_we_cyc);
                        end
`endif
                    end
                end
            end
        end
    end

    task automatic check_zero(input string nm);
        total++;
        if ({in_ready, mem_we, mem_adr, mem_wdata, cpu_hold, busy,
             done, words_written, chk_err} !== '0) begin
            bad++;
            $display("FAIL %s outputs not zero: rdy=%b we=%b adr=%0d wd=%h hold=%b busy=%b done=%b ww=%0d chk=%b want all 0",
                     nm, in_ready, mem_we, mem_adr, mem_wdata, cpu_hold, busy,
                     done, words_written, chk_err);
        end
    endtask

    task automatic run_load(input int base, input int cnt, input int mode,
                            input bit extra_in, input bit force_cks,
                            input logic [7:0] cks_val);
        int         n;
        bit         extra;
        bit         seen;
        int         hold;
        logic [7:0] b[$];
        logic [7:0] x;
        logic       expchk;
        wr_t        w;
        dn_t        d;
        n = (cnt > 1024) ? 1024 : cnt;
        extra = extra_in && n >= 2;
        if (fix.size() == 2 * n) b = fix;
        else for (int i = 0; i < 2 * n; i++) b.push_back(8'($urandom_range(0, 255)));
        fix.delete();
        x = 8'h00;
        expchk = 1'b0;
        for (int i = 0; i < n; i++) begin
            w.adr  = 10'((base + i) % 1024);
            w.data = {b[2*i], b[2*i+1]};
            wq.push_back(w);
            x = x ^ b[2*i] ^ b[2*i+1];
        end
        foreach (b[i]) src_q.push_back(b[i]);
`ifdef LOADER_CHECKSUM_EN
        if (n > 0) begin
            logic [7:0] c;
            c = force_cks ? cks_val : x;
            expchk = (c != x);
            src_q.push_back(c);
        end
`else
        if (force_cks && cks_val == 8'hFF) expchk = 1'b0;
`endif
        src_q.push_back(8'hA5);
        vmode = mode;
        @(negedge clk);
        base_adr = 10'(base);
        word_cnt = 11'(cnt);
        start    = 1'b1;
        d.words = n;
        d.chk   = expchk;
        d.zero  = (n == 0);
        d.scyc  = cyc;
        dq.push_back(d);
        seen = 1'b0;
        hold = 0;
        for (int k = 0; k < 100 + 12 * n; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 0) begin
                total++;
                if (words_written !== 11'd0 || chk_err !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL start_clear ww=%0d chk=%b busy=%b want 0 0 1",
                             words_written, chk_err, busy);
                end
                base_adr = 10'($urandom_range(0, 1023));
                word_cnt = 11'($urandom_range(0, 2047));
            end
            if (extra && k == 4) begin
                start    = 1'b1;
                base_adr = ~10'(base);
                word_cnt = 11'd1;
            end
            hold += int'(cpu_hold);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL timeout base=%0d cnt=%0d got no done want done", base, cnt);
        end
        if (n == 0) begin
            total++;
            if (hold != 1) begin
                bad++;
                $display("FAIL zero_hold got=%0d want=1", hold);
            end
        end
        #2;
        total++;
        if (src_q.size() != 1) begin
            bad++;
            $display("FAIL leftover_bytes got=%0d want=1", src_q.size());
        end
        src_q.delete();
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (int'(words_written) != n || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold ww=%0d busy=%b hold=%b want ww=%0d 0 0",
                     words_written, busy, cpu_hold, n);
        end
    endtask

    task automatic reset_mid_load();
        wr_t w;
        bit  ok;
        logic [7:0] b0, b1, b2;
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        w.adr  = 10'd600;
        w.data = {b0, b1};
        wq.push_back(w);
        src_q.push_back(b0);
        src_q.push_back(b1);
        src_q.push_back(b2);
        vmode = 0;
        @(negedge clk);
        base_adr = 10'd600;
        word_cnt = 11'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (wq.size() == 0 && src_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_setup got no first word want word 0 written");
        end
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        #1 check_zero("rst_mid");
        @(negedge clk);
        #1 rst = 1'b0;
        total++;
        if (wq.size() != 0) begin
            bad++;
            $display("FAIL rst_word0 pending=%0d want 0", wq.size());
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        base_adr = 10'd0;
        word_cnt = 11'd0;
        #3 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        fix = '{8'hC5, 8'h11, 8'h01, 8'hF4};
        run_load(0, 2, 0, 1'b0, 1'b0, 8'h00);
        run_load(77, 0, 0, 1'b0, 1'b0, 8'h00);
        fix = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
        run_load(1023, 3, 0, 1'b0, 1'b0, 8'h00);
        run_load(300, 5, 1, 1'b1, 1'b0, 8'h00);
        reset_mid_load();
        run_load(40, 2, 2, 1'b0, 1'b0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
        fix = '{8'h12, 8'h34};
        run_load(5, 1, 0, 1'b0, 1'b1, 8'h26);
        fix = '{8'h12, 8'h34};
        run_load(6, 1, 0, 1'b0, 1'b1, 8'h00);
        run_load(7, 1, 0, 1'b0, 1'b0, 8'h00);
`endif
        for (int i = 0; i < 10; i++) begin
            run_load($urandom_range(0, 1023), $urandom_range(0, 6),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        run_load(900, 1500, 0, 1'b0, 1'b0, 8'h00);

        total++;
        if (wq.size() != 0 || dq.size() != 0) begin
            bad++;
            $display("FAIL drain writes=%0d dones=%0d want 0 0", wq.size(), dq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
